// File: rtl/division_station_mlane_if.sv
// Issue/commit bundle of the multi-lane division station.
// The master side is the issuing client plus commit arbiter; the slave side is the station.
interface division_station_mlane_if #(
  parameter int LANES = 3,
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
);
  logic                   iFlush;
  logic                   iIssueValid;
  logic                   oIssueReady;
  logic [LANES*WIDTH-1:0] iDividend;
  logic [LANES*WIDTH-1:0] iDivisor;
  logic [2:0]             iScale;
  logic [TAG_W-1:0]       iTag;
  logic                   oBusy;
  logic                   oCommitRequest;
  logic                   iCommitGranted;
  logic [LANES*WIDTH-1:0] oResult;
  logic [TAG_W-1:0]       oTag;
  logic [LANES-1:0]       oDivByZero;
  logic [LANES-1:0]       oOverflow;

  modport master (
    output iFlush, iIssueValid, iDividend, iDivisor, iScale, iTag, iCommitGranted,
    input  oIssueReady, oBusy, oCommitRequest, oResult, oTag, oDivByZero, oOverflow
  );

  modport slave (
    input  iFlush, iIssueValid, iDividend, iDivisor, iScale, iTag, iCommitGranted,
    output oIssueReady, oBusy, oCommitRequest, oResult, oTag, oDivByZero, oOverflow
  );
endinterface

// File: rtl/division_station_mlane.sv
// Multi-lane signed fixed-point division station: lock-step restoring dividers on
// 2*WIDTH-bit magnitudes, with divide-by-zero/overflow saturation and a held commit.
module division_station_mlane #(
  parameter int LANES = 3,
  parameter int WIDTH = 32,
  parameter int FRAC  = 17,
  parameter int TAG_W = 4
) (
  input logic Clock,
  input logic Reset,
  division_station_mlane_if.slave bus
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [DW-1:0] MAG_LIM = DW'(1) << (WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, COMMIT} state_t;

  state_t state, stateNext;
  logic [CW-1:0] cnt;
  logic          accept;

  logic [DW-1:0]    remP   [LANES];
  logic [DW-1:0]    quoP   [LANES];
  logic [DW-1:0]    divMag [LANES];
  logic [LANES-1:0] negRes;
  logic [LANES-1:0] negDvd;

  logic [LANES*WIDTH-1:0] resultR;
  logic [TAG_W-1:0]       tagR;
  logic [LANES-1:0]       dzR;
  logic [LANES-1:0]       ovfR;

  // Sign-extend to 2*WIDTH, optionally pre-scale, and return the magnitude.
  function automatic logic [DW-1:0] magOf(input logic signed [WIDTH-1:0] v, input logic sh);
    logic signed [DW-1:0] x;
    x = {{WIDTH{v[WIDTH-1]}}, v};
    if (sh) x = x <<< FRAC;
    return x[DW-1] ? -x : x;
  endfunction

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  function automatic logic [2*DW-1:0] restoreStep(input logic [DW-1:0] rem, quo, div);
    logic [DW:0]   trial;
    logic [DW-1:0] diff;
    trial = {rem, quo[DW-1]};
    diff  = trial[DW-1:0] - div;
    if (trial >= {1'b0, div}) return {diff, quo[DW-2:0], 1'b1};
    return {trial[DW-1:0], quo[DW-2:0], 1'b0};
  endfunction

  // Returns {divByZero, overflow, quotient} for one lane.
  function automatic logic [WIDTH+1:0] saturate(input logic [DW-1:0] qMag,
                                                input logic neg, divZero, dvdNeg);
    logic [WIDTH-1:0] lo;
    lo = qMag[WIDTH-1:0];
    if (divZero) return {2'b10, dvdNeg ? Q_MIN : Q_MAX};
    if (neg) begin
      if (qMag > MAG_LIM) return {2'b01, Q_MIN};
      return {2'b00, -lo};
    end
    if (qMag >= MAG_LIM) return {2'b01, Q_MAX};
    return {2'b00, lo};
  endfunction

  assign accept = (state == IDLE) && bus.iIssueValid && !bus.iFlush;

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (bus.iFlush) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.iIssueValid) stateNext = CALC;
        CALC:    if (cnt == CW'(DW - 1)) stateNext = SIGN;
        SIGN:    stateNext = COMMIT;
        COMMIT:  if (bus.iCommitGranted) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      resultR <= '0;
      tagR    <= '0;
      dzR     <= '0;
      ovfR    <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        // Issue capture: quotient register is preloaded with the dividend magnitude.
        IDLE: if (accept) begin
          tagR <= bus.iTag;
          cnt  <= '0;
          for (int l = 0; l < LANES; l++) begin
            quoP[l]   <= magOf(bus.iDividend[l*WIDTH +: WIDTH], !bus.iScale[2] && bus.iScale[1]);
            divMag[l] <= magOf(bus.iDivisor[l*WIDTH +: WIDTH],  !bus.iScale[2] && bus.iScale[0]);
            remP[l]   <= '0;
            negRes[l] <= bus.iDividend[l*WIDTH + WIDTH - 1] ^ bus.iDivisor[l*WIDTH + WIDTH - 1];
            negDvd[l] <= bus.iDividend[l*WIDTH + WIDTH - 1];
          end
        end
        // Iteration: all lanes advance one quotient bit per edge.
        CALC: begin
          cnt <= cnt + 1'b1;
          for (int l = 0; l < LANES; l++)
            {remP[l], quoP[l]} <= restoreStep(remP[l], quoP[l], divMag[l]);
        end
        // Sign/saturation: apply the result sign and clamp to the WIDTH range.
        SIGN: if (!bus.iFlush) begin
          for (int l = 0; l < LANES; l++)
            {dzR[l], ovfR[l], resultR[l*WIDTH +: WIDTH]} <=
              saturate(quoP[l], negRes[l], divMag[l] == '0, negDvd[l]);
        end
        default: ;
      endcase
    end
  end

  assign bus.oIssueReady    = (state == IDLE);
  assign bus.oBusy          = (state != IDLE);
  assign bus.oCommitRequest = (state == COMMIT);
  assign bus.oResult        = resultR;
  assign bus.oTag           = tagR;
  assign bus.oDivByZero     = dzR;
  assign bus.oOverflow      = ovfR;

endmodule

// File: doc/division_station_mlane.md
# division_station_mlane

Parametrised multi-lane signed fixed-point division station, the next-generation replacement for the three-lane division station in the execution cluster. It accepts one issue of LANES packed operand pairs and applies the optional fractional pre-scale. It runs one iterative radix-2 divider per lane in lock-step and holds the saturated result, tag and per-lane exception flags on the commit interface until the commit arbiter grants. It adds divide-by-zero and overflow saturation with flags, issue/commit backpressure, and a flush.

## Interface
- LANES, 3, number of parallel lanes; lane i occupies bits [i*WIDTH +: WIDTH]; lane LANES-1 in the MSBs (X in the 3-lane build)
- WIDTH, 32, operand/result width per lane, two's complement
- FRAC, 17, fractional bits applied by the scale shift; legal range 1..WIDTH-1
- TAG_W, 4, width of the opaque issue tag (station id/destination handle)

Ports:
- Clock  in  1  single clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- iFlush  in  1  synchronous abort of any in-flight or held operation
- iIssueValid  in  1  issue request
- oIssueReady  out  1  station idle; issue accepted on edge where iIssueValid & oIssueReady
- iDividend  in  LANES*WIDTH  packed dividends
- iDivisor  in  LANES*WIDTH  packed divisors
- iScale  in  3  scale select: ~iScale[2]&iScale[1] shifts dividend left FRAC; ~iScale[2]&iScale[0] shifts divisor left FRAC
- iTag  in  TAG_W  returned unchanged with the result
- oBusy  out  1  ~oIssueReady
- oCommitRequest  out  1  result valid, held until granted
- iCommitGranted  in  1  arbiter grant
- oResult  out  LANES*WIDTH  packed quotients
- oTag  out  TAG_W  captured iTag
- oDivByZero  out  LANES  per-lane divisor==0 flag
- oOverflow  out  LANES  per-lane quotient saturation flag

## Operation
- States: IDLE, CALC, SIGN, COMMIT. Reset or iFlush forces IDLE on the same edge, overriding every other event. Reset zeroes all outputs except oIssueReady=1, oBusy=0. Flush drops oCommitRequest and leaves stale result bits; they carry no meaning.
- IDLE: accept edge captures iTag. Per lane it sign-extends both operands to 2*WIDTH, applies the scale shifts, stores magnitudes and the result sign (dividend sign XOR divisor sign) and the dividend sign, then enters CALC with counter=0. iIssueValid while busy is ignored, with no capture.
- CALC: one restoring step per edge on the 2*WIDTH-bit magnitudes, all lanes in lock-step. Leaves to SIGN after exactly 2*WIDTH edges, when the counter reaches 2*WIDTH-1.
- SIGN: per lane, one edge:
  - divisor magnitude 0 -> quotient 2^(WIDTH-1)-1 if dividend ≥ 0, else -2^(WIDTH-1); oDivByZero=1; oOverflow=0.
  - else the signed quotient, truncated toward zero, is checked against the WIDTH range. Out of range -> saturate to the same extreme as the true sign, oOverflow=1. Else the low WIDTH bits are output.
  - Sets oCommitRequest=1 and enters COMMIT.
- COMMIT: oResult/oTag/flags/oCommitRequest are stable. The edge sampling iCommitGranted=1 clears oCommitRequest and enters IDLE. Grant outside COMMIT is ignored.
- Remainder is discarded. The unscale step is not performed here; it belongs to the consumer.

## Timing
- Accept edge = edge 1. oCommitRequest rises after edge 2*WIDTH+2, which is edge 66 at WIDTH=32.
- Minimum issue-to-issue interval: 2*WIDTH+3 edges, with grant in the first COMMIT cycle.
- oIssueReady rises on the grant edge. A new issue can be accepted on the following edge.
- No combinational path from iIssueValid, iCommitGranted or iFlush to any output.
- Grant and flush on the same edge: flush wins, and the result is not committed.

## Test plan
- Integer, scale 000: dividends {100,-100,7}, divisors {7,7,-2} -> {14,-14,-3}, flags 0, request after edge 66, oTag echoes iTag=0xA.
- Fixed-point, scale 010: dividend 0x00060000 (3.0 Q17), divisor 0x00020000 (1.0) -> 0x00060000. Scale 001: dividend 6, divisor 0x00020000 -> 0.
- Divide by zero: dividends {5,-5,0}, divisors 0 -> {0x7FFFFFFF,0x80000000,0x7FFFFFFF}, oDivByZero=3'b111, oOverflow=0.
- Overflow, scale 010: dividend 0x7FFFFFFF, divisor 1 -> 0x7FFFFFFF with oOverflow=1. Dividend 0x80000000, divisor 1 -> 0x80000000 with oOverflow=1.
- Backpressure: grant held low 10 cycles -> request, result and flags stable. Issue pulsed while busy is ignored. One-cycle grant -> request low and oIssueReady high after that edge. Back-to-back issue next edge completes correctly.
- Flush at edge 20 of CALC, and separately Reset during COMMIT -> IDLE next edge, no request. A subsequent 84/-4 issue returns -21.
